// File: rtl/reg_wb_pkg.sv
// Shared defaults and requester encoding for the register-bank writeback scheduler.
package reg_wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_REG_COUNT  = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    typedef struct packed {
        logic valid;
        req_e src;
    } grant_t;

    function automatic req_e other_req(input req_e r);
        return (r == REQ_ALU) ? REQ_MEM : REQ_ALU;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Load-pending scoreboard: one busy bit per architectural register, a registered
// population count, and the decode hazard comparator.
module wb_scoreboard
    import reg_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int REG_COUNT  = WB_REG_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_is_load,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    input  logic                  clr_valid,
    input  logic [ADDR_WIDTH-1:0] clr_rd,
    output logic                  hazard_stall,
    output logic [ADDR_WIDTH:0]   pending_loads
);

    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] busy_nxt;
    logic [ADDR_WIDTH:0]  count_nxt;
    logic                 set_en;

    // Stall looks only at the registered busy vector; a clear this cycle is seen next cycle.
    always_comb begin
        hazard_stall = issue_valid &&
                       ((busy[issue_rs1] && (issue_rs1 != '0)) ||
                        (busy[issue_rs2] && (issue_rs2 != '0)) ||
                        (busy[issue_rd]  && (issue_rd  != '0)));
    end

    assign set_en = issue_valid && issue_is_load && !hazard_stall && (issue_rd != '0);

    always_comb begin
        // NOTE: start from a full default so every path assigns busy_nxt and no latch is inferred.
        busy_nxt = busy;
        if (clr_valid) begin
            busy_nxt[clr_rd] = 1'b0;
        end
        // Applied after the clear so a newly issued load overrides a completing one.
        if (set_en) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            count_nxt = count_nxt + (ADDR_WIDTH + 1)'(busy_nxt[i]);
        end
    end

    // Registering the count of busy_nxt keeps pending_loads equal to popcount(busy).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: busy is a flop vector rather than a RAM, so it is cleared by reset like any state.
            busy          <= '0;
            pending_loads <= '0;
        end else begin
            busy          <= busy_nxt;
            pending_loads <= count_nxt;
        end
    end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Writeback scheduler for the register bank's single write port: ALU/load arbitration,
// registered write port and load scoreboard. Define WB_FIXED_PRIO_EN for memory-first priority.
module reg_wb_scheduler
    import reg_wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int REG_COUNT  = WB_REG_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_is_load,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    output logic                  hazard_stall,
    input  logic                  alu_wb_valid,
    input  logic [ADDR_WIDTH-1:0] alu_wb_rd,
    input  logic [DATA_WIDTH-1:0] alu_wb_data,
    output logic                  alu_wb_ready,
    input  logic                  mem_wb_valid,
    input  logic [ADDR_WIDTH-1:0] mem_wb_rd,
    input  logic [DATA_WIDTH-1:0] mem_wb_data,
    output logic                  mem_wb_ready,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [ADDR_WIDTH:0]   pending_loads
);

    grant_t                grant;
    logic                  alu_wins;
    logic [ADDR_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_data;

`ifdef WB_FIXED_PRIO_EN
    // Memory wins contention; after three consecutive denials the ALU gets one grant.
    logic [1:0] alu_deny_cnt;

    assign alu_wins = alu_wb_valid && (!mem_wb_valid || (alu_deny_cnt == 2'd3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_deny_cnt <= 2'd0;
        end else if (alu_wb_valid && !alu_wins) begin
            alu_deny_cnt <= alu_deny_cnt + 2'd1;
        end else begin
            alu_deny_cnt <= 2'd0;
        end
    end
`else
    // Round-robin: the pointer names the contention winner and flips only after contention.
    req_e rr_ptr;

    assign alu_wins = alu_wb_valid && (!mem_wb_valid || (rr_ptr == REQ_ALU));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= REQ_MEM;
        end else if (alu_wb_valid && mem_wb_valid) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            rr_ptr <= other_req(rr_ptr);
        end
    end
`endif

    // Reset suppresses the grant immediately, so no handshake completes while rst is high.
    always_comb begin
        grant.valid = !rst && (alu_wb_valid || mem_wb_valid);
        grant.src   = alu_wins ? REQ_ALU : REQ_MEM;
    end

    assign alu_wb_ready = grant.valid && (grant.src == REQ_ALU);
    assign mem_wb_ready = grant.valid && (grant.src == REQ_MEM);

    always_comb begin
        win_rd   = alu_wb_rd;
        win_data = alu_wb_data;
        if (grant.src == REQ_MEM) begin
            win_rd   = mem_wb_rd;
            win_data = mem_wb_data;
        end
    end

    // x0 writes complete the handshake but never assert the bank write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant.valid) begin
            rf_we    <= (win_rd != '0);
            rf_waddr <= win_rd;
            rf_wdata <= win_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    wb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_is_load (issue_is_load),
        .issue_rd      (issue_rd),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .clr_valid     (mem_wb_ready),
        .clr_rd        (mem_wb_rd),
        .hazard_stall  (hazard_stall),
        .pending_loads (pending_loads)
    );

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Self-checking bench for reg_wb_scheduler: vector table, expected-write queue, reset corners.
module tb_reg_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_is_load;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        hazard_stall;
    logic        alu_wb_valid, alu_wb_ready;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        mem_wb_valid, mem_wb_ready;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [5:0]  pending_loads;

    always #5 clk = ~clk;

    reg_wb_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_is_load (issue_is_load),
        .issue_rd      (issue_rd),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .hazard_stall  (hazard_stall),
        .alu_wb_valid  (alu_wb_valid),
        .alu_wb_rd     (alu_wb_rd),
        .alu_wb_data   (alu_wb_data),
        .alu_wb_ready  (alu_wb_ready),
        .mem_wb_valid  (mem_wb_valid),
        .mem_wb_rd     (mem_wb_rd),
        .mem_wb_data   (mem_wb_data),
        .mem_wb_ready  (mem_wb_ready),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pending_loads (pending_loads)
    );

    typedef struct {
        string       name;
        logic        iv, il;
        logic [4:0]  rd, rs1, rs2;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        e_ar, e_mr, e_st, e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [5:0]  e_pend;
    } vec_t;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  pend;
    } wr_exp_t;

    vec_t    vecs[$];
    wr_exp_t exp_q[$];
    int      n_checks = 0;
    int      n_err    = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string name,
                                input logic iv, input logic il,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                                input logic e_ar, input logic e_mr, input logic e_st,
                                input logic e_we, input logic [4:0] e_waddr,
                                input logic [31:0] e_wdata, input logic [5:0] e_pend);
        vec_t v;
        v.name = name; v.iv = iv; v.il = il; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.av = av; v.ard = ard; v.adata = adata; v.mv = mv; v.mrd = mrd; v.mdata = mdata;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_st = e_st; v.e_we = e_we;
        v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic drive_idle();
        issue_valid = 1'b0; issue_is_load = 1'b0;
        issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; alu_wb_data = 32'h0;
        mem_wb_valid = 1'b0; mem_wb_rd = 5'd0; mem_wb_data = 32'h0;
    endtask

    task automatic pop_and_compare();
        wr_exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({e.name, ":rf_we"},         rf_we,         e.we);
            check({e.name, ":rf_waddr"},      rf_waddr,      e.waddr);
            check({e.name, ":rf_wdata"},      rf_wdata,      e.wdata);
            check({e.name, ":pending_loads"}, pending_loads, e.pend);
        end
    endtask

    // Drive one cycle of stimulus, check combinational outputs mid-cycle, then the write port.
    task automatic apply(input vec_t v);
        wr_exp_t e;
        @(negedge clk);
        issue_valid = v.iv; issue_is_load = v.il;
        issue_rd = v.rd; issue_rs1 = v.rs1; issue_rs2 = v.rs2;
        alu_wb_valid = v.av; alu_wb_rd = v.ard; alu_wb_data = v.adata;
        mem_wb_valid = v.mv; mem_wb_rd = v.mrd; mem_wb_data = v.mdata;
        #1;
        check({v.name, ":alu_wb_ready"}, alu_wb_ready, v.e_ar);
        check({v.name, ":mem_wb_ready"}, mem_wb_ready, v.e_mr);
        check({v.name, ":hazard_stall"}, hazard_stall, v.e_st);
        e.name = v.name; e.we = v.e_we; e.waddr = v.e_waddr; e.wdata = v.e_wdata; e.pend = v.e_pend;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pop_and_compare();
    endtask

    initial begin
        logic [7:0] mem_wins;
        logic       mw;

        // name, iv il rd rs1 rs2, alu v/rd/data, mem v/rd/data, exp ar mr st, exp we/waddr/wdata, exp pend
        vecs.push_back(mk("contend_first", 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22,
                          1'b0,1'b1,1'b0, 1'b1,5'd4,32'h22, 6'd0));
`ifdef WB_FIXED_PRIO_EN
        vecs.push_back(mk("contend_mem_again", 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd3,32'h11, 1'b1,5'd6,32'h66,
                          1'b0,1'b1,1'b0, 1'b1,5'd6,32'h66, 6'd0));
        vecs.push_back(mk("alu_alone", 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd3,32'h11, 1'b0,5'd0,32'h0,
                          1'b1,1'b0,1'b0, 1'b1,5'd3,32'h11, 6'd0));
        mem_wins = 8'b0111_0111;
`else
        vecs.push_back(mk("contend_rr_alu", 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd3,32'h11, 1'b1,5'd6,32'h66,
                          1'b1,1'b0,1'b0, 1'b1,5'd3,32'h11, 6'd0));
        vecs.push_back(mk("mem_alone", 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd6,32'h66,
                          1'b0,1'b1,1'b0, 1'b1,5'd6,32'h66, 6'd0));
        mem_wins = 8'b1010_1010;
`endif
        vecs.push_back(mk("x0_write_and_load", 1'b1,1'b1,5'd0,5'd0,5'd0, 1'b1,5'd0,32'hFFFF_FFFF, 1'b0,5'd0,32'h0,
                          1'b1,1'b0,1'b0, 1'b0,5'd0,32'hFFFF_FFFF, 6'd0));
        vecs.push_back(mk("load_rd5", 1'b1,1'b1,5'd5,5'd1,5'd2, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,
                          1'b0,1'b0,1'b0, 1'b0,5'd0,32'hFFFF_FFFF, 6'd1));
        vecs.push_back(mk("raw_rs1", 1'b1,1'b0,5'd10,5'd5,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,
                          1'b0,1'b0,1'b1, 1'b0,5'd0,32'hFFFF_FFFF, 6'd1));
        vecs.push_back(mk("raw_rs2", 1'b1,1'b0,5'd10,5'd0,5'd5, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,
                          1'b0,1'b0,1'b1, 1'b0,5'd0,32'hFFFF_FFFF, 6'd1));
        vecs.push_back(mk("no_issue", 1'b0,1'b0,5'd10,5'd5,5'd5, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,
                          1'b0,1'b0,1'b0, 1'b0,5'd0,32'hFFFF_FFFF, 6'd1));
        vecs.push_back(mk("load_wb5_stall_held", 1'b1,1'b0,5'd10,5'd5,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd5,32'hDEAD_BEEF,
                          1'b0,1'b1,1'b1, 1'b1,5'd5,32'hDEAD_BEEF, 6'd0));
        vecs.push_back(mk("stall_released", 1'b1,1'b0,5'd10,5'd5,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,
                          1'b0,1'b0,1'b0, 1'b0,5'd5,32'hDEAD_BEEF, 6'd0));
        vecs.push_back(mk("set_wins_over_clr", 1'b1,1'b1,5'd7,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd7,32'h77,
                          1'b0,1'b1,1'b0, 1'b1,5'd7,32'h77, 6'd1));
        vecs.push_back(mk("waw_load_stalled", 1'b1,1'b1,5'd7,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd8,32'h88,
                          1'b0,1'b1,1'b1, 1'b1,5'd8,32'h88, 6'd1));
        vecs.push_back(mk("clear_rd7", 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd7,32'h70,
                          1'b0,1'b1,1'b0, 1'b1,5'd7,32'h70, 6'd0));
        vecs.push_back(mk("load_rd9", 1'b1,1'b1,5'd9,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,
                          1'b0,1'b0,1'b0, 1'b0,5'd7,32'h70, 6'd1));
        vecs.push_back(mk("waw_nonload", 1'b1,1'b0,5'd9,5'd1,5'd1, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,
                          1'b0,1'b0,1'b1, 1'b0,5'd7,32'h70, 6'd1));
        vecs.push_back(mk("stalled_load_no_set", 1'b1,1'b1,5'd12,5'd9,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,
                          1'b0,1'b0,1'b1, 1'b0,5'd7,32'h70, 6'd1));
        vecs.push_back(mk("contend_mem_wins", 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd11,32'hA1, 1'b1,5'd9,32'h99,
                          1'b0,1'b1,1'b0, 1'b1,5'd9,32'h99, 6'd0));
        vecs.push_back(mk("alu_alone_2", 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd11,32'hA1, 1'b0,5'd0,32'h0,
                          1'b1,1'b0,1'b0, 1'b1,5'd11,32'hA1, 6'd0));

        // Reset held with both requesters valid: nothing may be granted or written.
        rst = 1'b1;
        drive_idle();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h11;
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd4; mem_wb_data = 32'h22;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset:alu_wb_ready",  alu_wb_ready,  32'd0);
        check("reset:mem_wb_ready",  mem_wb_ready,  32'd0);
        check("reset:rf_we",         rf_we,         32'd0);
        check("reset:rf_waddr",      rf_waddr,      32'd0);
        check("reset:rf_wdata",      rf_wdata,      32'd0);
        check("reset:pending_loads", pending_loads, 32'd0);
        check("reset:hazard_stall",  hazard_stall,  32'd0);
        rst = 1'b0;
        drive_idle();

        foreach (vecs[i]) apply(vecs[i]);

        // Continuous contention for eight cycles; the expected winner pattern depends on the mode.
        for (int i = 0; i < 8; i++) begin
            mw = mem_wins[i];
            apply(mk($sformatf("contend_seq%0d", i), 1'b0,1'b0,5'd0,5'd0,5'd0,
                     1'b1,5'd13,32'hAAAA, 1'b1,5'd14,32'hBBBB,
                     !mw, mw, 1'b0, 1'b1, mw ? 5'd14 : 5'd13, mw ? 32'hBBBB : 32'hAAAA, 6'd0));
        end

        // Asynchronous reset mid-cycle with a busy register, a prior write and both requesters valid.
        apply(mk("pre_reset", 1'b1,1'b1,5'd20,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd21,32'h21,
                 1'b0,1'b1,1'b0, 1'b1,5'd21,32'h21, 6'd1));
        @(negedge clk);
        issue_valid = 1'b1; issue_is_load = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd20; issue_rs2 = 5'd0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd13; alu_wb_data = 32'hAAAA;
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd14; mem_wb_data = 32'hBBBB;
        #1;
        check("pre_reset:hazard_stall", hazard_stall, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_reset:alu_wb_ready",  alu_wb_ready,  32'd0);
        check("mid_reset:mem_wb_ready",  mem_wb_ready,  32'd0);
        check("mid_reset:hazard_stall",  hazard_stall,  32'd0);
        check("mid_reset:rf_we",         rf_we,         32'd0);
        check("mid_reset:rf_waddr",      rf_waddr,      32'd0);
        check("mid_reset:rf_wdata",      rf_wdata,      32'd0);
        check("mid_reset:pending_loads", pending_loads, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();

        // The arbitration state must be back to memory-first after reset.
        apply(mk("post_reset_contend", 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd13,32'hAAAA, 1'b1,5'd14,32'hBBBB,
                 1'b0,1'b1,1'b0, 1'b1,5'd14,32'hBBBB, 6'd0));

        check("expected_queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
